// File: rtl/pc_fetch_ctrl_pkg.sv
// Shared definitions for the instruction-fetch sequencer: next-PC op
// encodings, fetch FSM states and the default reset PC.
package pc_fetch_ctrl_pkg;

  localparam logic [1:0] NPC_SEQ  = 2'd0;
  localparam logic [1:0] NPC_REL  = 2'd1;
  localparam logic [1:0] NPC_JALR = 2'd2;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_DRAIN,
    S_HALT
  } fetch_state_t;

endpackage

// File: rtl/pc_fetch_ctrl_npc_target.sv
// Combinational redirect target: pc-relative (jal/branch) or register-based
// (jalr, bit 0 cleared). Flags whether the op requests a redirect at all.
module npc_target
  import pc_fetch_ctrl_pkg::*;
(
  input  logic [1:0]  npc_op,
  input  logic [31:0] ex_pc,
  input  logic [31:0] imm,
  input  logic [31:0] base,
  output logic [31:0] target,
  output logic        is_redirect
);

  logic [31:0] rel_sum;
  logic [31:0] jalr_sum;

  always_comb begin
    rel_sum     = ex_pc + imm;
    jalr_sum    = (base + imm) & ~32'd1;
    target      = rel_sum;
    is_redirect = 1'b0;
    case (npc_op)
      NPC_REL: begin
        target      = rel_sum;
        is_redirect = 1'b1;
      end
      NPC_JALR: begin
        target      = jalr_sum;
        is_redirect = 1'b1;
      end
      NPC_SEQ: begin
        target      = rel_sum;
        is_redirect = 1'b0;
      end
      default: begin
        target      = rel_sum;
        is_redirect = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, drives the req/ack imem port and
// presents one instruction at a time to decode, applying execute redirects.
module pc_fetch_ctrl
  import pc_fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        npc_valid,
  input  logic [1:0]  npc_op,
  input  logic [31:0] ex_pc,
  input  logic [31:0] imm,
  input  logic [31:0] base,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic [31:0] inst_pc4,
  output logic        misalign
);

  fetch_state_t state;
  fetch_state_t state_nxt;

  logic [31:0] pc;
  logic        pending;
  logic [31:0] held_addr;

  logic [31:0] target;
  logic        op_redirect;
  logic        slot_free;
  logic        redirect;
  logic        bad_target;
  logic        load;

  npc_target u_npc_target (
    .npc_op      (npc_op),
    .ex_pc       (ex_pc),
    .imm         (imm),
    .base        (base),
    .target      (target),
    .is_redirect (op_redirect)
  );

  always_comb begin
    slot_free  = !inst_valid || !stall;
    redirect   = npc_valid && op_redirect &&
                 ((state == S_FETCH) || (state == S_DRAIN));
    bad_target = redirect && target[1];
    load       = imem_req && imem_ack && (state == S_FETCH) && !redirect;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  state_nxt = S_FETCH;
      S_FETCH: begin
        if (bad_target)                              state_nxt = S_HALT;
        else if (redirect && imem_req && !imem_ack)  state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (bad_target)    state_nxt = S_HALT;
        else if (imem_ack) state_nxt = S_FETCH;
      end
      S_HALT:  state_nxt = S_HALT;
      default: state_nxt = S_IDLE;
    endcase
  end

  // A raised request is held (with its address) until ack in every state,
  // so a new request is only opened from FETCH when the slot can take it.
  always_comb begin
    imem_req  = 1'b0;
    imem_addr = pending ? held_addr : pc;
    case (state)
      S_FETCH: imem_req = pending || slot_free;
      S_DRAIN: imem_req = pending;
      S_HALT:  imem_req = pending;
      default: imem_req = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc         <= RESET_PC;
      pending    <= 1'b0;
      held_addr  <= RESET_PC;
      inst_valid <= 1'b0;
      inst       <= '0;
      inst_pc    <= '0;
      inst_pc4   <= '0;
      misalign   <= 1'b0;
    end else begin
      pending  <= imem_req && !imem_ack;
      misalign <= bad_target;
      if (imem_req) held_addr <= imem_addr;

      if (redirect)  pc <= target;
      else if (load) pc <= pc + 32'd4;

      if (redirect || (state == S_HALT)) begin
        inst_valid <= 1'b0;
      end else if (load) begin
        inst_valid <= 1'b1;
        inst       <= imem_rdata;
        inst_pc    <= pc;
        inst_pc4   <= pc + 32'd4;
      end else if (inst_valid && !stall) begin
        inst_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Bench for pc_fetch_ctrl: two instances (default and wrapping RESET_PC) share
// stimulus; each is checked every cycle against a transaction-level model.
module tb_pc_fetch_ctrl;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        npc_valid;
  logic [1:0]  npc_op;
  logic [31:0] ex_pc;
  logic [31:0] imm;
  logic [31:0] base;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  logic        o_req  [2];
  logic [31:0] o_addr [2];
  logic        o_iv   [2];
  logic [31:0] o_inst [2];
  logic [31:0] o_pc   [2];
  logic [31:0] o_pc4  [2];
  logic        o_mis  [2];

  int total;
  int bad;

  localparam logic [31:0] RPC0 = 32'h0000_0000;
  localparam logic [31:0] RPC1 = 32'hFFFF_FFFC;

  pc_fetch_ctrl dut0 (
    .clk(clk), .rst(rst), .stall(stall), .npc_valid(npc_valid), .npc_op(npc_op),
    .ex_pc(ex_pc), .imm(imm), .base(base), .imem_req(o_req[0]), .imem_addr(o_addr[0]),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .inst_valid(o_iv[0]), .inst(o_inst[0]),
    .inst_pc(o_pc[0]), .inst_pc4(o_pc4[0]), .misalign(o_mis[0])
  );

  pc_fetch_ctrl #(.RESET_PC(RPC1)) dut1 (
    .clk(clk), .rst(rst), .stall(stall), .npc_valid(npc_valid), .npc_op(npc_op),
    .ex_pc(ex_pc), .imm(imm), .base(base), .imem_req(o_req[1]), .imem_addr(o_addr[1]),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .inst_valid(o_iv[1]), .inst(o_inst[1]),
    .inst_pc(o_pc[1]), .inst_pc4(o_pc4[1]), .misalign(o_mis[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural model: started = one cycle past reset; outst = a request is
  // open at oaddr; discard = the open request's data belongs to a dead path.
  typedef struct {
    bit          started;
    bit          halted;
    bit          outst;
    bit          discard;
    bit          sv;
    bit          mis;
    logic [31:0] pc;
    logic [31:0] oaddr;
    logic [31:0] si;
    logic [31:0] spc;
  } mdl_t;

  mdl_t m [2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] rpc(input int i);
    return (i == 0) ? RPC0 : RPC1;
  endfunction

  task automatic model_reset(input int i);
    m[i].started = 0; m[i].halted = 0; m[i].outst = 0; m[i].discard = 0;
    m[i].sv = 0; m[i].mis = 0; m[i].pc = rpc(i); m[i].oaddr = rpc(i);
    m[i].si = '0; m[i].spc = '0;
  endtask

  function automatic bit exp_req(input int i);
    return m[i].outst || (m[i].started && !m[i].halted && (!m[i].sv || !stall));
  endfunction

  task automatic model_step(input int i);
    bit          req, acc, redir, ld, outst_n;
    logic [31:0] tgt, a;
    req   = exp_req(i);
    a     = m[i].outst ? m[i].oaddr : m[i].pc;
    acc   = req && imem_ack;
    redir = m[i].started && !m[i].halted && npc_valid && (npc_op == 2'd1 || npc_op == 2'd2);
    tgt   = (npc_op == 2'd1) ? ex_pc + imm : ((base + imm) & 32'hFFFF_FFFE);
    ld    = acc && !m[i].discard && !redir && !m[i].halted;
    if (redir || m[i].halted) m[i].sv = 0;
    else if (ld) begin
      m[i].sv = 1; m[i].si = imem_rdata; m[i].spc = m[i].pc;
    end else if (m[i].sv && !stall) m[i].sv = 0;
    if (redir)   m[i].pc = tgt;
    else if (ld) m[i].pc = m[i].pc + 32'd4;
    m[i].mis     = redir && tgt[1];
    outst_n      = req && !imem_ack;
    m[i].discard = outst_n && (m[i].discard || redir);
    m[i].outst   = outst_n;
    m[i].oaddr   = a;
    m[i].halted  = m[i].halted || (redir && tgt[1]);
    m[i].started = 1;
  endtask

  task automatic compare(input int i);
    bit er;
    er = exp_req(i);
    chk($sformatf("d%0d.req", i), 32'(o_req[i]), 32'(er));
    if (er) chk($sformatf("d%0d.addr", i), o_addr[i], m[i].outst ? m[i].oaddr : m[i].pc);
    chk($sformatf("d%0d.inst_valid", i), 32'(o_iv[i]), 32'(m[i].sv));
    if (m[i].sv) begin
      chk($sformatf("d%0d.inst", i), o_inst[i], m[i].si);
      chk($sformatf("d%0d.inst_pc", i), o_pc[i], m[i].spc);
      chk($sformatf("d%0d.inst_pc4", i), o_pc4[i], m[i].spc + 32'd4);
    end
    chk($sformatf("d%0d.misalign", i), 32'(o_mis[i]), 32'(m[i].mis));
  endtask

  // Inputs are already driven (posedge+1); compare, advance models, next edge.
  task automatic cycle();
    if (rst) begin
      model_reset(0);
      model_reset(1);
    end
    #2;
    compare(0);
    compare(1);
    if (!rst) begin
      model_step(0);
      model_step(1);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set(input bit st, input bit nv, input logic [1:0] op,
                     input logic [31:0] ep, input logic [31:0] im,
                     input logic [31:0] bs, input bit ak);
    stall = st; npc_valid = nv; npc_op = op; ex_pc = ep; imm = im; base = bs;
    imem_ack = ak; imem_rdata = $urandom;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    set(0, 0, 2'd0, '0, '0, '0, 0);
    model_reset(0);
    model_reset(1);
    repeat (2) @(posedge clk);
    #1;
    chk("reset.req", 32'(o_req[0]), 32'd0);
    chk("reset.addr0", o_addr[0], 32'h0);
    chk("reset.addr1", o_addr[1], 32'hFFFF_FFFC);
    chk("reset.valid", 32'(o_iv[0]), 32'd0);
    chk("reset.inst", o_inst[0], 32'h0);
    chk("reset.pc4", o_pc4[0], 32'h0);

    // Streaming after release, including the wrapping instance.
    rst = 1'b0;
    set(0, 0, 2'd0, '0, '0, '0, 1);
    cycle();
    chk("idle.valid", 32'(o_iv[0]), 32'd0);
    set(0, 0, 2'd0, '0, '0, '0, 1); cycle();
    chk("first.valid", 32'(o_iv[0]), 32'd1);
    chk("first.pc0", o_pc[0], 32'h0);
    chk("first.pc1", o_pc[1], 32'hFFFF_FFFC);
    chk("first.pc4_1", o_pc4[1], 32'h0);
    set(0, 0, 2'd0, '0, '0, '0, 1); cycle();
    chk("second.pc0", o_pc[0], 32'h4);
    chk("second.pc1", o_pc[1], 32'h0);
    set(0, 0, 2'd0, '0, '0, '0, 1); cycle();
    chk("third.pc0", o_pc[0], 32'h8);

    // Stall holds the slot and blocks new requests.
    for (int unsigned k = 0; k < 3; k++) begin
      set(1, 0, 2'd0, '0, '0, '0, 1); cycle();
    end
    chk("stall.pc0", o_pc[0], 32'h8);
    chk("stall.valid", 32'(o_iv[0]), 32'd1);
    set(0, 0, 2'd0, '0, '0, '0, 1); cycle();
    chk("unstall.pc0", o_pc[0], 32'hC);

    // Redirect op1 while a request is open, ack two cycles later.
    set(0, 1, 2'd1, 32'h100, 32'h40, '0, 0); cycle();
    chk("drain.valid", 32'(o_iv[0]), 32'd0);
    chk("drain.addr", o_addr[0], 32'h10);
    chk("drain.req", 32'(o_req[0]), 32'd1);
    set(0, 0, 2'd0, '0, '0, '0, 0); cycle();
    set(0, 0, 2'd0, '0, '0, '0, 1); cycle();
    chk("redir.valid", 32'(o_iv[0]), 32'd0);
    chk("redir.addr", o_addr[0], 32'h140);
    set(0, 0, 2'd0, '0, '0, '0, 1); cycle();
    chk("redir.pc0", o_pc[0], 32'h140);

    // Misaligned jalr with ack in the same cycle.
    set(0, 1, 2'd2, '0, 32'h0, 32'h203, 1); cycle();
    chk("mis.pulse", 32'(o_mis[0]), 32'd1);
    chk("mis.valid", 32'(o_iv[0]), 32'd0);
    chk("mis.req", 32'(o_req[0]), 32'd0);
    for (int unsigned k = 0; k < 3; k++) begin
      set(0, 0, 2'd0, '0, '0, '0, 1); cycle();
    end
    chk("halt.pulse", 32'(o_mis[0]), 32'd0);
    chk("halt.req", 32'(o_req[0]), 32'd0);

    // Reset while a request is open; late ack is ignored.
    rst = 1'b1; set(0, 0, 2'd0, '0, '0, '0, 0); cycle();
    rst = 1'b0; set(0, 0, 2'd0, '0, '0, '0, 0); cycle();
    set(0, 0, 2'd0, '0, '0, '0, 0); cycle();
    chk("pend.req", 32'(o_req[0]), 32'd1);
    rst = 1'b1;
    #1;
    chk("async.req", 32'(o_req[0]), 32'd0);
    set(0, 0, 2'd0, '0, '0, '0, 1); cycle();
    set(0, 0, 2'd0, '0, '0, '0, 1); cycle();
    rst = 1'b0; set(0, 0, 2'd0, '0, '0, '0, 1); cycle();
    chk("late.valid", 32'(o_iv[0]), 32'd0);
    set(0, 0, 2'd0, '0, '0, '0, 1); cycle();
    chk("rerun.valid", 32'(o_iv[0]), 32'd1);
    chk("rerun.pc0", o_pc[0], 32'h0);

    // Randomized traffic with rare misaligned targets and resets.
    for (int unsigned k = 0; k < 4000; k++) begin
      logic [31:0] r_imm, r_base, r_ep;
      r_imm  = {$urandom, 2'b00};
      r_base = {$urandom} & 32'hFFFF_FFFD;
      r_ep   = {$urandom, 2'b00};
      if ($urandom_range(0, 31) == 0) r_imm  = $urandom;
      if ($urandom_range(0, 31) == 0) r_base = $urandom;
      rst = ($urandom_range(0, 249) == 0);
      set($urandom_range(0, 9) < 3, $urandom_range(0, 99) < 15, 2'($urandom_range(0, 3)),
          r_ep, r_imm, r_base, $urandom_range(0, 9) < 6);
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
